ifetch_ctrl: RTL



---
 rtl/ifetch_ctrl_if.sv | 26 ++
 rtl/ifetch_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/ifetch_ctrl_if.sv
// Fetch-stage bus: instruction ROM port, hazard/redirect inputs, and the
// IF/ID register outputs with the fetch status.
interface ifetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   // The fetch unit.
   modport master (
      output imem_addr, if_id_inst, if_id_pc4, if_id_valid, halted, fetch_count,
      input  imem_inst, stall, redirect_valid, redirect_pc
   );

   // ROM, hazard unit and downstream stages.
   modport slave (
      input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, halted, fetch_count,
      output imem_inst, stall, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC and the IF/ID register.
// BOOT spends one cycle with a bubble, RUN fetches sequentially and honours
// redirects and stalls, and HALTED is entered on a jump-to-self and left
// only through reset.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input logic          clk,
   input logic          reset,
   ifetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

   state_t      state_p0, state_n;
   logic [31:0] pc_p0, pc_n;
   logic [31:0] inst_p1, inst_n;
   logic [31:0] pc4_p1, pc4_n;
   logic        vld_p1, vld_n;
   logic        halted_p1, halted_n;
   logic [15:0] count_p1, count_n;

   logic [31:0] pc_plus4;
   logic        self_jump;

   // Saturating increment so the fetch counter sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign pc_plus4  = pc_p0 + 32'd4;
   assign self_jump = (bus.imem_inst[31:26] == 6'b000010) &&
                      ({pc_plus4[31:28], bus.imem_inst[25:0], 2'b00} == pc_p0);

   // Next-state and next-register selection; every branch starts from hold.
   always_comb begin
      state_n  = state_p0;
      pc_n     = pc_p0;
      inst_n   = inst_p1;
      pc4_n    = pc4_p1;
      vld_n    = vld_p1;
      count_n  = count_p1;
      halted_n = 1'b0;
      unique case (state_p0)
         BOOT: begin
            pc_n    = RESET_PC;
            inst_n  = '0;
            pc4_n   = '0;
            vld_n   = 1'b0;
            state_n = RUN;
         end
         RUN: begin
            if (bus.redirect_valid) begin
               // Redirect beats stall; target is forced word-aligned.
               pc_n   = {bus.redirect_pc[31:2], 2'b00};
               inst_n = '0;
               pc4_n  = '0;
               vld_n  = 1'b0;
            end else if (!bus.stall) begin
               inst_n  = bus.imem_inst;
               pc4_n   = pc_plus4;
               vld_n   = 1'b1;
               count_n = sat_inc(count_p1);
               if (self_jump) begin
                  state_n  = HALTED;
                  halted_n = 1'b1;
               end else begin
                  pc_n = pc_plus4;
               end
            end
         end
         HALTED: begin
            inst_n   = '0;
            pc4_n    = '0;
            vld_n    = 1'b0;
            halted_n = 1'b1;
         end
         default: begin
            state_n = BOOT;
         end
      endcase
   end

   // PC / IF-ID stage boundary, cleared asynchronously to the boot state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_p0  <= BOOT;
         pc_p0     <= RESET_PC;
         inst_p1   <= '0;
         pc4_p1    <= '0;
         vld_p1    <= 1'b0;
         halted_p1 <= 1'b0;
         count_p1  <= '0;
      end else begin
         state_p0  <= state_n;
         pc_p0     <= pc_n;
         inst_p1   <= inst_n;
         pc4_p1    <= pc4_n;
         vld_p1    <= vld_n;
         halted_p1 <= halted_n;
         count_p1  <= count_n;
      end
   end

   assign bus.imem_addr   = pc_p0;
   assign bus.if_id_inst  = inst_p1;
   assign bus.if_id_pc4   = pc4_p1;
   assign bus.if_id_valid = vld_p1;
   assign bus.halted      = halted_p1;
   assign bus.fetch_count = count_p1;

endmodule
